// File: rtl/led_cmd_pkg.sv
// Shared command/status definitions for the LED pattern engine:
// opcode and mode enums, status bit positions and per-mode seed patterns.
package led_cmd_pkg;

  typedef enum logic [2:0] {
    OP_OFF     = 3'd0,
    OP_STATIC  = 3'd1,
    OP_BLINK   = 3'd2,
    OP_SHIFT_L = 3'd3,
    OP_SHIFT_R = 3'd4,
    OP_BOUNCE  = 3'd5,
    OP_COUNT   = 3'd6,
    OP_RSVD    = 3'd7
  } led_op_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STATIC,
    ST_BLINK,
    ST_SHIFT_L,
    ST_SHIFT_R,
    ST_BOUNCE_UP,
    ST_BOUNCE_DN,
    ST_COUNT
  } led_mode_e;

  localparam int unsigned CMD_TOG_BIT  = 7;
  localparam int unsigned CMD_OP_LSB   = 4;

  localparam int unsigned STAT_ACK_BIT = 7;
  localparam int unsigned STAT_OP_LSB  = 4;
  localparam int unsigned STAT_ERR_BIT = 3;
  localparam int unsigned STAT_HB_BIT  = 2;

  localparam logic [7:0] SEED_BLINK   = 8'hFF;
  localparam logic [7:0] SEED_SHIFT_L = 8'h01;
  localparam logic [7:0] SEED_SHIFT_R = 8'h80;
  localparam logic [7:0] SEED_BOUNCE  = 8'h01;
  localparam logic [7:0] SEED_COUNT   = 8'h00;

  // Both bounce directions report the single BOUNCE opcode to the host.
  function automatic led_op_e mode_to_op(input led_mode_e m);
    led_op_e op;
    case (m)
      ST_OFF:       op = OP_OFF;
      ST_STATIC:    op = OP_STATIC;
      ST_BLINK:     op = OP_BLINK;
      ST_SHIFT_L:   op = OP_SHIFT_L;
      ST_SHIFT_R:   op = OP_SHIFT_R;
      ST_BOUNCE_UP: op = OP_BOUNCE;
      ST_BOUNCE_DN: op = OP_BOUNCE;
      default:      op = OP_COUNT;
    endcase
    return op;
  endfunction

  function automatic logic mode_animated(input led_mode_e m);
    return (m != ST_OFF) && (m != ST_STATIC);
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step timer: a TICK_DIV prescaler followed by a rate counter; emits a
// one-cycle step every (rate+1)*TICK_DIV cycles after the last clear.
module led_step_timer #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       clear,
  input  logic [3:0] rate,
  output logic       step
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    rate_q, rate_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    step    = tick && (rate_q >= rate);
    presc_d = presc_q + 1'b1;
    rate_d  = rate_q;
    if (clear) begin
      presc_d = '0;
      rate_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      rate_d  = step ? '0 : rate_q + 4'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q <= '0;
      rate_q  <= '0;
    end else begin
      presc_q <= presc_d;
      rate_q  <= rate_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine driven by a toggle-strobed command word from the HPS PIO.
// Optional macro LED_CMD_SYNC_EN adds a 2-flop synchronizer on cmd_i.
module led_pattern_engine
  import led_cmd_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 2500000,
  parameter logic [7:0]  RESET_PATTERN = 8'h00
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] cmd_i,
  output logic [7:0] status_o,
  output logic [7:0] led_o
);

  logic [7:0] cmd_s;

`ifdef LED_CMD_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cmd_i;
      sync2_q <= sync1_q;
    end
  end

  assign cmd_s = sync2_q;
`else
  assign cmd_s = cmd_i;
`endif

  logic       last_tog_q, last_tog_d;
  logic       pend_q, pend_d;
  led_op_e    pend_op_q, pend_op_d;
  logic [3:0] pend_arg_q, pend_arg_d;

  led_mode_e  mode_q, mode_d;
  logic [7:0] led_q, led_d;
  logic [3:0] arg_q, arg_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       hb_q, hb_d;
  logic       step;

  // First stage: detect the toggle edge and latch the command fields.
  always_comb begin
    last_tog_d = cmd_s[CMD_TOG_BIT];
    pend_d     = cmd_s[CMD_TOG_BIT] ^ last_tog_q;
    pend_op_d  = pend_op_q;
    pend_arg_d = pend_arg_q;
    if (pend_d) begin
      pend_op_d  = led_op_e'(cmd_s[CMD_OP_LSB +: 3]);
      pend_arg_d = cmd_s[3:0];
    end
  end

  // Second stage: a pending command always wins over a coincident step.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    arg_d  = arg_q;
    ack_d  = ack_q;
    err_d  = err_q;
    hb_d   = hb_q;
    if (pend_q) begin
      ack_d = last_tog_q;
      if (pend_op_q == OP_RSVD) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        arg_d = pend_arg_q;
        case (pend_op_q)
          OP_OFF:     begin mode_d = ST_OFF;       led_d = '0;                       end
          OP_STATIC:  begin mode_d = ST_STATIC;    led_d = {pend_arg_q, pend_arg_q}; end
          OP_BLINK:   begin mode_d = ST_BLINK;     led_d = SEED_BLINK;               end
          OP_SHIFT_L: begin mode_d = ST_SHIFT_L;   led_d = SEED_SHIFT_L;             end
          OP_SHIFT_R: begin mode_d = ST_SHIFT_R;   led_d = SEED_SHIFT_R;             end
          OP_BOUNCE:  begin mode_d = ST_BOUNCE_UP; led_d = SEED_BOUNCE;              end
          OP_COUNT:   begin mode_d = ST_COUNT;     led_d = SEED_COUNT;               end
          default:    ;
        endcase
      end
    end else if (step) begin
      hb_d = mode_animated(mode_q) ? ~hb_q : hb_q;
      case (mode_q)
        ST_BLINK:   led_d = ~led_q;
        ST_SHIFT_L: led_d = {led_q[6:0], led_q[7]};
        ST_SHIFT_R: led_d = {led_q[0], led_q[7:1]};
        ST_BOUNCE_UP, ST_BOUNCE_DN: begin
          if (led_q == 8'h80) begin
            led_d  = 8'h40;
            mode_d = ST_BOUNCE_DN;
          end else if (led_q == 8'h01) begin
            led_d  = 8'h02;
            mode_d = ST_BOUNCE_UP;
          end else if (mode_q == ST_BOUNCE_UP) begin
            led_d  = {led_q[6:0], 1'b0};
          end else begin
            led_d  = {1'b0, led_q[7:1]};
          end
        end
        ST_COUNT:   led_d = led_q + 8'd1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_tog_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_op_q  <= OP_OFF;
      pend_arg_q <= '0;
      mode_q     <= ST_OFF;
      led_q      <= RESET_PATTERN;
      arg_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      hb_q       <= 1'b0;
    end else begin
      last_tog_q <= last_tog_d;
      pend_q     <= pend_d;
      pend_op_q  <= pend_op_d;
      pend_arg_q <= pend_arg_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      arg_q      <= arg_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      hb_q       <= hb_d;
    end
  end

  // Clearing on the pending cycle makes the first step land one full period after the seed load.
  led_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .clear         (pend_q),
    .rate          (arg_q),
    .step          (step)
  );

  always_comb begin
    status_o                    = '0;
    status_o[STAT_ACK_BIT]      = ack_q;
    status_o[STAT_OP_LSB +: 3]  = mode_to_op(mode_q);
    status_o[STAT_ERR_BIT]      = err_q;
    status_o[STAT_HB_BIT]       = hb_q;
  end

  assign led_o = led_q;

endmodule
